// File: rtl/biu_bus_arbiter_if.sv
// Request/grant bundle between the BIU masters and the bus arbiter.
interface biu_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] i_req;
  logic [NUM_MASTERS-1:0] o_gnt;
  logic [OWNER_W-1:0]     o_owner;
  logic                   o_bus_busy;
  logic [NUM_MASTERS-1:0] o_preempt;

  modport master (output i_req, input o_gnt, o_owner, o_bus_busy, o_preempt);
  modport slave  (input i_req, output o_gnt, o_owner, o_bus_busy, o_preempt);
endinterface

// File: rtl/biu_bus_arbiter.sv
// Round-robin owner arbiter for the shared tri-state BIU bus: idle turnaround between
// owners and an optional hold limit that preempts an owner while others wait.
module biu_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned TURNAROUND  = 1,
  parameter int unsigned MAX_HOLD    = 8
) (
  input logic              clk,
  input logic              n_rst,
  biu_bus_arbiter_if.slave bus
);
  localparam int unsigned OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned TURN_W  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURNAROUND - 1);
  localparam logic [OWNER_W-1:0] PTR_RST   = OWNER_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_TURN
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [NUM_MASTERS-1:0] r_preempt;
  logic [OWNER_W-1:0]     r_owner;
  logic [OWNER_W-1:0]     r_rr_ptr;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [TURN_W-1:0]      r_turn_cnt;
  logic                   r_busy;

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_others;
  logic                   w_hold_hit;
  logic                   w_win_found;
  logic [OWNER_W-1:0]     w_win_idx;
  int unsigned            w_scan;

  assign w_req      = bus.i_req;
  assign w_others   = w_req & ~r_gnt;
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM) && (|w_others);

  // First requester after the last winner, wrapping around the master ring.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      w_scan = (32'(r_rr_ptr) + k) % NUM_MASTERS;
      if (!w_win_found && w_req[OWNER_W'(w_scan)]) begin
        w_win_found = 1'b1;
        w_win_idx   = OWNER_W'(w_scan);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_preempt  <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= PTR_RST;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_preempt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_state    <= ST_OWNED;
            r_gnt      <= NUM_MASTERS'(1) << w_win_idx;
            r_owner    <= w_win_idx;
            r_rr_ptr   <= w_win_idx;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        ST_OWNED: begin
          // Release outranks the hold limit, so a simultaneous drop never pulses preempt.
          if (!w_req[r_owner] || w_hold_hit) begin
            r_state    <= ST_TURN;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            if (w_req[r_owner]) begin
              r_preempt <= r_gnt;
            end
          end else if (r_hold_cnt != HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_TURN: begin
          if (r_turn_cnt != TURN_LAST) begin
            r_turn_cnt <= r_turn_cnt + TURN_W'(1);
          end else if (w_win_found) begin
            r_state    <= ST_OWNED;
            r_gnt      <= NUM_MASTERS'(1) << w_win_idx;
            r_owner    <= w_win_idx;
            r_rr_ptr   <= w_win_idx;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_gnt      = r_gnt;
  assign bus.o_owner    = r_owner;
  assign bus.o_bus_busy = r_busy;
  assign bus.o_preempt  = r_preempt;
endmodule
